gb80_regfile: RTL and testbench
===============================

# gb80_regfile

Second-generation GB80 register file: eight byte registers (B, C, D, E, H, L, F, A) plus 16-bit SP and PC, with two registered byte read ports, one byte write port, a 16-bit pair port supporting write and increment/decrement, masked flag update, and a self-incrementing program counter. It sits between the instruction decoder/sequencer and the ALU/address bus, and replaces the single-port file.

## Interface
- DATA_WIDTH, 8, byte register width; pairs and PC are 2*DATA_WIDTH.
- SP_RESET, 16'hFFFE, SP reset value.
- PC_RESET, 16'h0000, PC reset value.
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_wr_en  in  1  byte write strobe.
- i_wr_addr  in  3  byte write select: 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 F, 7 A.
- i_wr_data  in  DATA_WIDTH  byte write data.
- i_rd_en  in  1  load both read ports.
- i_rd_a_addr, i_rd_b_addr  in  3 each  read selects, same encoding as i_wr_addr.
- o_rd_a_data, o_rd_b_data  out  DATA_WIDTH each  registered read data.
- i_pair_addr  in  2  pair select: 0 BC, 1 DE, 2 HL, 3 SP.
- i_pair_wr_en  in  1  pair write strobe.
- i_pair_wr_data  in  2*DATA_WIDTH  pair write data; high byte to B/D/H.
- i_pair_op  in  2  00 none, 01 increment, 10 decrement, 11 none.
- i_pair_rd_en  in  1  load pair read port.
- o_pair_data  out  2*DATA_WIDTH  registered pair read data.
- i_flag_wr_mask  in  4  per-bit enable for Z, N, H, C (bit 3 = Z).
- i_flags  in  4  new Z, N, H, C values.
- o_flags  out  4  current F[DATA_WIDTH-1 -: 4], combinational from F.
- i_pc_wr_en  in  1  PC load strobe.
- i_pc_data  in  2*DATA_WIDTH  PC load value.
- i_pc_inc  in  1  PC increment strobe.
- o_pc  out  2*DATA_WIDTH  current PC, direct register output.

## Operation
- Reset: B–A and F cleared to 0, SP = SP_RESET, PC = PC_RESET, o_rd_a_data/o_rd_b_data/o_pair_data = 0.
- F low DATA_WIDTH-4 bits are hard-wired 0; any write to F stores only the top nibble.
- Byte write: on edge with i_wr_en, selected register takes i_wr_data.
- Pair write: on edge with i_pair_wr_en, both bytes (or SP) take i_pair_wr_data; i_pair_op ignored that cycle.
- Pair op: inc/dec of selected pair, modulo 2^(2*DATA_WIDTH) (FFFF+1 = 0000, 0000-1 = FFFF); no flags affected.
- Flag update: each F flag bit with mask=1 takes i_flags bit; others hold.
- Priority per register: pair write > pair op > byte write > flag update. Byte write and pair access to disjoint registers both take effect in the same cycle.
- PC: i_pc_wr_en > i_pc_inc; increment wraps FFFF -> 0000.
- Reads: with i_rd_en, both ports capture the selected registers; without, outputs hold. Pair read likewise with i_pair_rd_en. Read ports hold across writes.

## Timing
- Read latency: 1 cycle (address at edge N, data valid after edge N).
- Write-to-state latency: 1 cycle; o_pc and o_flags reflect updates immediately after the edge.
- Reset asserted mid-operation clears state asynchronously; pending strobes in the reset cycle are discarded.

## Configuration
- GB80_RF_BYPASS_EN defined: a read (byte or pair) in the same cycle as a write/op to that register returns the post-update value (forwarding applies the full priority resolution).
- Undefined: same-cycle read returns the pre-update value; new value visible on the next read.

## Test plan
- Reset with SP_RESET default -> all byte reads 00, pair 3 reads FFFE, o_pc 0000, o_flags 0.
- Write B=12, C=34, then pair read BC -> o_pair_data 1234; byte read of C on port A and B on port B simultaneously -> 34/12.
- HL=FFFF, pair op inc -> HL 0000; decrement -> FFFF; PC=FFFF with i_pc_inc -> 0000; i_pc_wr_en=1 and i_pc_inc=1 with 0100 -> PC 0100.
- Byte write F=FF -> read F F0; mask 0101 with flags 0000 -> o_flags 1010.
- Same cycle: byte write D=AA, pair write DE=5566 -> DE 5566; byte write B=77 with pair inc DE -> B 77, DE 5567.
- Write A=3C with simultaneous read of A -> 3C with GB80_RF_BYPASS_EN, previous A without.

Source files
------------

// File: rtl/gb80_regfile.sv
// GB80 register file: eight byte registers (B,C,D,E,H,L,F,A), SP and PC, with registered byte/pair read ports.
// Optional macro GB80_RF_BYPASS_EN forwards same-cycle updates to the read ports.
module gb80_regfile #(
    parameter int                      DATA_WIDTH = 8,
    parameter logic [2*DATA_WIDTH-1:0] SP_RESET   = 16'hFFFE,
    parameter logic [2*DATA_WIDTH-1:0] PC_RESET   = 16'h0000
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_wr_en,
    input  logic [2:0]                i_wr_addr,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic                      i_rd_en,
    input  logic [2:0]                i_rd_a_addr,
    input  logic [2:0]                i_rd_b_addr,
    output logic [DATA_WIDTH-1:0]     o_rd_a_data,
    output logic [DATA_WIDTH-1:0]     o_rd_b_data,
    input  logic [1:0]                i_pair_addr,
    input  logic                      i_pair_wr_en,
    input  logic [2*DATA_WIDTH-1:0]   i_pair_wr_data,
    input  logic [1:0]                i_pair_op,
    input  logic                      i_pair_rd_en,
    output logic [2*DATA_WIDTH-1:0]   o_pair_data,
    input  logic [3:0]                i_flag_wr_mask,
    input  logic [3:0]                i_flags,
    output logic [3:0]                o_flags,
    input  logic                      i_pc_wr_en,
    input  logic [2*DATA_WIDTH-1:0]   i_pc_data,
    input  logic                      i_pc_inc,
    output logic [2*DATA_WIDTH-1:0]   o_pc
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [2:0] F_IDX = 3'd6;
    localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] regs      [8];
    logic [DATA_WIDTH-1:0] regs_next [8];
    logic [DATA_WIDTH-1:0] rd_src    [8];
    logic [PW-1:0]         sp, sp_next, rd_sp;
    logic [PW-1:0]         pc, pc_next;
    logic [PW-1:0]         pair_cur, pair_new, pair_rd_val;
    logic                  pair_touch;

    always_comb begin
        case (i_pair_addr)
            2'd0:    pair_cur = {regs[0], regs[1]};
            2'd1:    pair_cur = {regs[2], regs[3]};
            2'd2:    pair_cur = {regs[4], regs[5]};
            default: pair_cur = sp;
        endcase
    end

    always_comb begin
        pair_new   = pair_cur;
        pair_touch = 1'b0;
        if (i_pair_wr_en) begin
            pair_new   = i_pair_wr_data;
            pair_touch = 1'b1;
        end else if (i_pair_op == 2'b01) begin
            pair_new   = pair_cur + ONE;
            pair_touch = 1'b1;
        end else if (i_pair_op == 2'b10) begin
            pair_new   = pair_cur - ONE;
            pair_touch = 1'b1;
        end
    end

    // Later assignments override earlier ones, so the order below encodes
    // priority from lowest (flag update) to highest (pair write/op).
    always_comb begin
        regs_next = regs;
        sp_next   = sp;
        regs_next[F_IDX][DATA_WIDTH-1 -: 4] =
            (regs[F_IDX][DATA_WIDTH-1 -: 4] & ~i_flag_wr_mask) | (i_flags & i_flag_wr_mask);
        if (i_wr_en) begin
            regs_next[i_wr_addr] = i_wr_data;
        end
        if (pair_touch) begin
            if (i_pair_addr == 2'd3) begin
                sp_next = pair_new;
            end else begin
                regs_next[{i_pair_addr, 1'b0}] = pair_new[PW-1 -: DATA_WIDTH];
                regs_next[{i_pair_addr, 1'b1}] = pair_new[DATA_WIDTH-1:0];
            end
        end
        regs_next[F_IDX][DATA_WIDTH-5:0] = '0;
    end

    always_comb begin
        pc_next = pc;
        if (i_pc_wr_en) begin
            pc_next = i_pc_data;
        end else if (i_pc_inc) begin
            pc_next = pc + ONE;
        end
    end

`ifdef GB80_RF_BYPASS_EN
    always_comb begin
        rd_src = regs_next;
        rd_sp  = sp_next;
    end
`else
    always_comb begin
        rd_src = regs;
        rd_sp  = sp;
    end
`endif

    always_comb begin
        case (i_pair_addr)
            2'd0:    pair_rd_val = {rd_src[0], rd_src[1]};
            2'd1:    pair_rd_val = {rd_src[2], rd_src[3]};
            2'd2:    pair_rd_val = {rd_src[4], rd_src[5]};
            default: pair_rd_val = rd_sp;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            sp          <= SP_RESET;
            pc          <= PC_RESET;
            o_rd_a_data <= '0;
            o_rd_b_data <= '0;
            o_pair_data <= '0;
        end else begin
            regs <= regs_next;
            sp   <= sp_next;
            pc   <= pc_next;
            if (i_rd_en) begin
                o_rd_a_data <= rd_src[i_rd_a_addr];
                o_rd_b_data <= rd_src[i_rd_b_addr];
            end
            if (i_pair_rd_en) begin
                o_pair_data <= pair_rd_val;
            end
        end
    end

    assign o_flags = regs[F_IDX][DATA_WIDTH-1 -: 4];
    assign o_pc    = pc;

endmodule

// File: tb/tb_gb80_regfile.sv
// Self-checking bench for gb80_regfile: table of directed vectors plus an asynchronous reset sequence.
// Expectations for the same-cycle read case follow GB80_RF_BYPASS_EN.
module tb_gb80_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [2:0]  rd_a_addr, rd_b_addr;
    logic [7:0]  rd_a_data, rd_b_data;
    logic [1:0]  pair_addr;
    logic        pair_wr_en;
    logic [15:0] pair_wr_data;
    logic [1:0]  pair_op;
    logic        pair_rd_en;
    logic [15:0] pair_data;
    logic [3:0]  flag_mask, flags_in, flags_out;
    logic        pc_wr_en;
    logic [15:0] pc_data;
    logic        pc_inc;
    logic [15:0] pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gb80_regfile dut (
        .i_clk(clk), .i_reset(rst),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_rd_a_addr(rd_a_addr), .i_rd_b_addr(rd_b_addr),
        .o_rd_a_data(rd_a_data), .o_rd_b_data(rd_b_data),
        .i_pair_addr(pair_addr), .i_pair_wr_en(pair_wr_en), .i_pair_wr_data(pair_wr_data),
        .i_pair_op(pair_op), .i_pair_rd_en(pair_rd_en), .o_pair_data(pair_data),
        .i_flag_wr_mask(flag_mask), .i_flags(flags_in), .o_flags(flags_out),
        .i_pc_wr_en(pc_wr_en), .i_pc_data(pc_data), .i_pc_inc(pc_inc), .o_pc(pc)
    );

    typedef struct {
        logic        wr_en;
        logic [2:0]  wr_addr;
        logic [7:0]  wr_data;
        logic        rd_en;
        logic [2:0]  rd_a;
        logic [2:0]  rd_b;
        logic [1:0]  pair_addr;
        logic        pair_wr_en;
        logic [15:0] pair_wr_data;
        logic [1:0]  pair_op;
        logic        pair_rd_en;
        logic [3:0]  mask;
        logic [3:0]  flags;
        logic        pc_wr_en;
        logic [15:0] pc_data;
        logic        pc_inc;
        logic [7:0]  exp_a;
        logic [7:0]  exp_b;
        logic [15:0] exp_pair;
        logic [3:0]  exp_flags;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t tbl[$];
    vec_t v;

    function automatic vec_t blank();
        vec_t b;
        b = '{default: '0};
        return b;
    endfunction

    function automatic vec_t withExp(vec_t b, logic [7:0] a, logic [7:0] bb, logic [15:0] p,
                                     logic [3:0] f, logic [15:0] c);
        b.exp_a = a; b.exp_b = bb; b.exp_pair = p; b.exp_flags = f; b.exp_pc = c;
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idleInputs();
        wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_a_addr = 0; rd_b_addr = 0;
        pair_addr = 0; pair_wr_en = 0; pair_wr_data = 0; pair_op = 0; pair_rd_en = 0;
        flag_mask = 0; flags_in = 0; pc_wr_en = 0; pc_data = 0; pc_inc = 0;
    endtask

    task automatic applyStimulus(input vec_t s);
        wr_en = s.wr_en; wr_addr = s.wr_addr; wr_data = s.wr_data;
        rd_en = s.rd_en; rd_a_addr = s.rd_a; rd_b_addr = s.rd_b;
        pair_addr = s.pair_addr; pair_wr_en = s.pair_wr_en; pair_wr_data = s.pair_wr_data;
        pair_op = s.pair_op; pair_rd_en = s.pair_rd_en;
        flag_mask = s.mask; flags_in = s.flags;
        pc_wr_en = s.pc_wr_en; pc_data = s.pc_data; pc_inc = s.pc_inc;
        @(posedge clk);
        #1;
        idleInputs();
    endtask

    initial begin
        logic [7:0] a_same;
`ifdef GB80_RF_BYPASS_EN
        a_same = 8'h3C;
`else
        a_same = 8'h00;
`endif
        // v0: read A/B and SP after reset
        v = blank(); v.rd_en = 1; v.rd_a = 7; v.rd_b = 0; v.pair_rd_en = 1; v.pair_addr = 3;
        tbl.push_back(withExp(v, 8'h00, 8'h00, 16'hFFFE, 4'h0, 16'h0000));
        v = blank(); v.wr_en = 1; v.wr_addr = 0; v.wr_data = 8'h12;
        tbl.push_back(withExp(v, 8'h00, 8'h00, 16'hFFFE, 4'h0, 16'h0000));
        v = blank(); v.wr_en = 1; v.wr_addr = 1; v.wr_data = 8'h34;
        tbl.push_back(withExp(v, 8'h00, 8'h00, 16'hFFFE, 4'h0, 16'h0000));
        v = blank(); v.rd_en = 1; v.rd_a = 1; v.rd_b = 0; v.pair_rd_en = 1; v.pair_addr = 0;
        tbl.push_back(withExp(v, 8'h34, 8'h12, 16'h1234, 4'h0, 16'h0000));
        v = blank(); v.pair_wr_en = 1; v.pair_addr = 2; v.pair_wr_data = 16'hFFFF;
        tbl.push_back(withExp(v, 8'h34, 8'h12, 16'h1234, 4'h0, 16'h0000));
        v = blank(); v.pair_op = 2'b01; v.pair_addr = 2;
        tbl.push_back(withExp(v, 8'h34, 8'h12, 16'h1234, 4'h0, 16'h0000));
        v = blank(); v.pair_rd_en = 1; v.pair_addr = 2;
        tbl.push_back(withExp(v, 8'h34, 8'h12, 16'h0000, 4'h0, 16'h0000));
        v = blank(); v.pair_op = 2'b10; v.pair_addr = 2;
        tbl.push_back(withExp(v, 8'h34, 8'h12, 16'h0000, 4'h0, 16'h0000));
        v = blank(); v.pair_rd_en = 1; v.pair_addr = 2; v.rd_en = 1; v.rd_a = 4; v.rd_b = 5;
        tbl.push_back(withExp(v, 8'hFF, 8'hFF, 16'hFFFF, 4'h0, 16'h0000));
        v = blank(); v.pc_wr_en = 1; v.pc_data = 16'hFFFF;
        tbl.push_back(withExp(v, 8'hFF, 8'hFF, 16'hFFFF, 4'h0, 16'hFFFF));
        v = blank(); v.pc_inc = 1;
        tbl.push_back(withExp(v, 8'hFF, 8'hFF, 16'hFFFF, 4'h0, 16'h0000));
        v = blank(); v.pc_wr_en = 1; v.pc_data = 16'h0100; v.pc_inc = 1;
        tbl.push_back(withExp(v, 8'hFF, 8'hFF, 16'hFFFF, 4'h0, 16'h0100));
        // v12: F low nibble is hard-wired to zero
        v = blank(); v.wr_en = 1; v.wr_addr = 6; v.wr_data = 8'hFF;
        tbl.push_back(withExp(v, 8'hFF, 8'hFF, 16'hFFFF, 4'hF, 16'h0100));
        v = blank(); v.rd_en = 1; v.rd_a = 6; v.rd_b = 6;
        tbl.push_back(withExp(v, 8'hF0, 8'hF0, 16'hFFFF, 4'hF, 16'h0100));
        v = blank(); v.mask = 4'b0101; v.flags = 4'b0000;
        tbl.push_back(withExp(v, 8'hF0, 8'hF0, 16'hFFFF, 4'hA, 16'h0100));
        // v15: pair write beats byte write on D
        v = blank(); v.wr_en = 1; v.wr_addr = 2; v.wr_data = 8'hAA;
        v.pair_wr_en = 1; v.pair_addr = 1; v.pair_wr_data = 16'h5566;
        tbl.push_back(withExp(v, 8'hF0, 8'hF0, 16'hFFFF, 4'hA, 16'h0100));
        v = blank(); v.pair_rd_en = 1; v.pair_addr = 1;
        tbl.push_back(withExp(v, 8'hF0, 8'hF0, 16'h5566, 4'hA, 16'h0100));
        v = blank(); v.wr_en = 1; v.wr_addr = 0; v.wr_data = 8'h77; v.pair_op = 2'b01; v.pair_addr = 1;
        tbl.push_back(withExp(v, 8'hF0, 8'hF0, 16'h5566, 4'hA, 16'h0100));
        v = blank(); v.pair_rd_en = 1; v.pair_addr = 1; v.rd_en = 1; v.rd_a = 0; v.rd_b = 2;
        tbl.push_back(withExp(v, 8'h77, 8'h55, 16'h5567, 4'hA, 16'h0100));
        // v19: write A and read A in the same cycle
        v = blank(); v.wr_en = 1; v.wr_addr = 7; v.wr_data = 8'h3C; v.rd_en = 1; v.rd_a = 7; v.rd_b = 7;
        tbl.push_back(withExp(v, a_same, a_same, 16'h5567, 4'hA, 16'h0100));
        v = blank(); v.rd_en = 1; v.rd_a = 7; v.rd_b = 7;
        tbl.push_back(withExp(v, 8'h3C, 8'h3C, 16'h5567, 4'hA, 16'h0100));
        // v21: byte write to F beats flag update
        v = blank(); v.wr_en = 1; v.wr_addr = 6; v.wr_data = 8'h00; v.mask = 4'hF; v.flags = 4'hF;
        tbl.push_back(withExp(v, 8'h3C, 8'h3C, 16'h5567, 4'h0, 16'h0100));
        v = blank(); v.pair_wr_en = 1; v.pair_addr = 3; v.pair_wr_data = 16'h0000;
        tbl.push_back(withExp(v, 8'h3C, 8'h3C, 16'h5567, 4'h0, 16'h0100));
        v = blank(); v.pair_op = 2'b10; v.pair_addr = 3;
        tbl.push_back(withExp(v, 8'h3C, 8'h3C, 16'h5567, 4'h0, 16'h0100));
        v = blank(); v.pair_rd_en = 1; v.pair_addr = 3;
        tbl.push_back(withExp(v, 8'h3C, 8'h3C, 16'hFFFF, 4'h0, 16'h0100));
        v = blank(); v.pair_op = 2'b11; v.pair_addr = 3;
        tbl.push_back(withExp(v, 8'h3C, 8'h3C, 16'hFFFF, 4'h0, 16'h0100));
        v = blank(); v.pair_rd_en = 1; v.pair_addr = 3;
        tbl.push_back(withExp(v, 8'h3C, 8'h3C, 16'hFFFF, 4'h0, 16'h0100));
        // v27: pair write ignores the pair op in the same cycle
        v = blank(); v.pair_wr_en = 1; v.pair_addr = 0; v.pair_wr_data = 16'hABCD; v.pair_op = 2'b01;
        tbl.push_back(withExp(v, 8'h3C, 8'h3C, 16'hFFFF, 4'h0, 16'h0100));
        v = blank(); v.pair_rd_en = 1; v.pair_addr = 0;
        tbl.push_back(withExp(v, 8'h3C, 8'h3C, 16'hABCD, 4'h0, 16'h0100));

        idleInputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_rd_a", {8'h00, rd_a_data}, 16'h0000);
        checkOutput("reset_rd_b", {8'h00, rd_b_data}, 16'h0000);
        checkOutput("reset_pair", pair_data, 16'h0000);
        checkOutput("reset_flags", {12'h000, flags_out}, 16'h0000);
        checkOutput("reset_pc", pc, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("v%0d_rd_a", i), {8'h00, rd_a_data}, {8'h00, tbl[i].exp_a});
            checkOutput($sformatf("v%0d_rd_b", i), {8'h00, rd_b_data}, {8'h00, tbl[i].exp_b});
            checkOutput($sformatf("v%0d_pair", i), pair_data, tbl[i].exp_pair);
            checkOutput($sformatf("v%0d_flags", i), {12'h000, flags_out}, {12'h000, tbl[i].exp_flags});
            checkOutput($sformatf("v%0d_pc", i), pc, tbl[i].exp_pc);
        end

        // Load flags, then assert reset mid-cycle with strobes pending.
        v = blank(); v.mask = 4'hF; v.flags = 4'hF;
        applyStimulus(v);
        checkOutput("pre_reset_flags", {12'h000, flags_out}, 16'h000F);
        wr_en = 1; wr_addr = 0; wr_data = 8'h99; pc_inc = 1; flag_mask = 4'hF; flags_in = 4'hF;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_pc", pc, 16'h0000);
        checkOutput("async_rst_flags", {12'h000, flags_out}, 16'h0000);
        checkOutput("async_rst_rd_a", {8'h00, rd_a_data}, 16'h0000);
        checkOutput("async_rst_pair", pair_data, 16'h0000);
        @(posedge clk);
        #1;
        idleInputs();
        rst = 1'b0;
        v = blank(); v.rd_en = 1; v.rd_a = 0; v.rd_b = 6; v.pair_rd_en = 1; v.pair_addr = 3;
        applyStimulus(v);
        checkOutput("post_rst_b", {8'h00, rd_a_data}, 16'h0000);
        checkOutput("post_rst_f", {8'h00, rd_b_data}, 16'h0000);
        checkOutput("post_rst_sp", pair_data, 16'hFFFE);
        checkOutput("post_rst_pc", pc, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
